pipe_cu: RTL and testbench
==========================

Name: pipe_cu

Overview:
- Parametrised pipelined control unit for the 5-stage RV32I core.
- Decodes the decode-stage instruction and registers its control word into execute.
- Carries writeback/memory controls down a configurable stage chain.
- Resolves all six conditional branches plus JAL/JALR in execute from ALU flags, and self-flushes the wrong-path decode slot.

Parameters:
- ALU_CTRL_W, 4, width of the ALU control field; must be ≥4.
- PIPE_DEPTH, 3, number of registered stages after decode carrying reg_write/result_src/mem_write (E, M, W); legal range 1–4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- instr_d  in  32  decode-stage instruction
- en_e  in  1  D→E register load enable (0 = hold)
- flush_e  in  1  load bubble into D→E register (from hazard unit)
- zero_e  in  1  ALU result == 0 (rs1−rs2)
- lt_e  in  1  signed rs1 < rs2
- ltu_e  in  1  unsigned rs1 < rs2
- imm_src_d  out  3  immediate format, combinational from instr_d
- alu_src_e  out  1  0 = rs2, 1 = immediate
- alu_ctrl_e  out  ALU_CTRL_W  ALU operation
- pc_src_e  out  1  redirect PC this cycle
- pc_sel_e  out  1  0 = PC+imm target, 1 = ALU result (JALR)
- flush_d_o  out  1  kill F/D register; equals pc_src_e
- reg_write_s  out  PIPE_DEPTH  reg_write per stage, bit 0 = E
- result_src_s  out  2*PIPE_DEPTH  result_src per stage: 00 ALU, 01 mem, 10 PC+4
- mem_write_s  out  PIPE_DEPTH  mem_write per stage

Behaviour:
- Decode (combinational, from op = instr_d[6:0], funct3 = [14:12], funct7[5] = bit 30):
  - R 0110011: reg write, ALU src = rs2.
  - I-ALU 0010011: reg write, imm I; funct7[5] is honoured only for shifts.
  - load 0000011: imm I, ADD, result mem.
  - store 0100011: imm S, ADD, mem write.
  - branch 1100011: imm B, SUB, branch.
  - JAL 1101111: imm J, jump, result PC+4.
  - JALR 1100111: imm I, ADD, jump, pc_sel = 1, result PC+4.
  - LUI 0110111: imm U, ALU op PASSB.
- imm_src encoding: I 000, S 001, B 010, J 011, U 100.
- alu_ctrl encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10; upper bits zero when ALU_CTRL_W > 4.
- Unrecognised opcode decodes to a bubble.
- Bubble: reg_write, mem_write, branch and jump = 0; remaining fields = 0.
- D→E register update priority, per rising clk:
  - !rst_n → bubble.
  - else flush_e | pc_src_e → bubble.
  - else en_e → decoded word.
  - else hold.
- Stage chain: stages 1..PIPE_DEPTH−1 shift every cycle from the previous stage and ignore en_e; only rst_n clears them.
- Branch resolution (combinational from registered branch, jump, funct3_e and the flags):
  - funct3 000: zero_e
  - 001: ~zero_e
  - 100: lt_e
  - 101: ~lt_e
  - 110: ltu_e
  - 111: ~ltu_e
  - 010/011: 0
- pc_src_e = jump_e | (branch_e & cond). Same-cycle as the flags, zero latency.
- Decode to E-stage outputs: 1 cycle. Decode to stage k: k+1 cycles.
- Self-flush: when pc_src_e = 1, the instruction in decode is squashed next cycle regardless of en_e.
- Simultaneous flush_e and pc_src_e: single bubble, no extra effect.
- Reset mid-operation: all stage registers become bubbles on the same edge. pc_src_e = 0 in the cycle after reset.
- All outputs are 0 under reset, except imm_src_d (combinational from instr_d).

Optional Feature:
- Macro: PIPE_CU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_e (1 bit). It registers, through the D→E priority rules, whether instr_d has an unrecognised opcode or an R-type funct7 other than 0000000/0100000.
  - Adds output illegal_sticky (1 bit). It sets when illegal_e = 1 and clears only on reset.
  - A flushed slot never raises illegal_e.
- Undefined: neither port exists; illegal encodings silently become bubbles.

Test Plan:
- Reset: hold rst_n = 0 with instr_d = add x1,x2,x3 (0x003100B3) for 2 cycles → all stage outputs 0, pc_src_e = 0; release → next edge reg_write_s[0] = 1, alu_ctrl_e = 0.
- Pipeline latency: lw x5,0(x1) (0x0000A283), then NOPs → result_src_s = 01 in stage 0 at cycle 1, stage 1 at cycle 2, stage 2 at cycle 3; mem_write_s stays 0.
- Branch matrix: beq/bne/blt/bge/bltu/bgeu in E with every combination of {zero_e, lt_e, ltu_e} → pc_src_e follows the funct3 table. funct3 = 010 → pc_src_e = 0.
- Self-flush: taken beq in E while sw (0x0020A023) is in decode → flush_d_o = 1; next cycle mem_write_s[0] = 0, and mem_write_s never goes to 1 for that sw.
- Stall/flush priority: en_e = 0 holds the E word for 3 cycles while stages 1+ drain. en_e = 0 with flush_e = 1 → bubble. jalr → pc_src_e = 1, pc_sel_e = 1, result_src = 10.
- With PIPE_CU_ILLEGAL_TRAP_EN: instr_d = 0xFFFFFFFF → illegal_e = 1 one cycle later and illegal_sticky stays 1 until reset. The same input with flush_e = 1 → illegal_e = 0.

Source files
------------

// File: rtl/pipe_cu.sv
// -----------------------------------------------------------------------------
// pipe_cu -- pipelined control unit for the 5-stage RV32I core.
//
// Decodes the instruction sitting in decode, registers its control word into
// execute (D->E register), resolves conditional branches and jumps in execute
// from the ALU flags, and carries reg_write / result_src / mem_write down a
// chain of PIPE_DEPTH registered stages (stage 0 = E, then M, W, ...).
//
// Parameters:
//   ALU_CTRL_W  width of the ALU control field (>= 4, upper bits zero)
//   PIPE_DEPTH  registered stages carrying the writeback/memory controls (1..4)
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   instr_d             decode-stage instruction
//   en_e                D->E load enable (0 = hold)
//   flush_e             load a bubble into the D->E register
//   zero_e/lt_e/ltu_e   ALU flags of the instruction in execute
//   imm_src_d           immediate format (combinational from instr_d)
//   alu_src_e           0 = rs2, 1 = immediate
//   alu_ctrl_e          ALU operation
//   pc_src_e            redirect the PC this cycle
//   pc_sel_e            0 = PC+imm target, 1 = ALU result (JALR)
//   flush_d_o           kill the F/D register (same as pc_src_e)
//   reg_write_s         reg_write per stage, bit 0 = E
//   result_src_s        result_src per stage (2 bits each): 00 ALU, 01 mem, 10 PC+4
//   mem_write_s         mem_write per stage
//
// Optional feature (macro PIPE_CU_ILLEGAL_TRAP_EN):
//   illegal_e           registered "illegal encoding in execute" flag
//   illegal_sticky      sets with illegal_e, cleared only by reset
// Without the macro these ports do not exist and illegal encodings simply
// decode to bubbles.
// -----------------------------------------------------------------------------
module pipe_cu #(
    parameter int ALU_CTRL_W = 4,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             instr_d,
    input  logic                    en_e,
    input  logic                    flush_e,
    input  logic                    zero_e,
    input  logic                    lt_e,
    input  logic                    ltu_e,
    output logic [2:0]              imm_src_d,
    output logic                    alu_src_e,
    output logic [ALU_CTRL_W-1:0]   alu_ctrl_e,
    output logic                    pc_src_e,
    output logic                    pc_sel_e,
    output logic                    flush_d_o,
    output logic [PIPE_DEPTH-1:0]   reg_write_s,
    output logic [2*PIPE_DEPTH-1:0] result_src_s,
    output logic [PIPE_DEPTH-1:0]   mem_write_s
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_e,
    output logic                    illegal_sticky
`endif
);

    // ------------------------------------------------------------------ types
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    // Control word held in the D->E register. An all-zero word is a bubble.
    typedef struct packed {
        logic     reg_write;
        res_src_e result_src;
        logic     mem_write;
        logic     branch;
        logic     jump;
        logic     alu_src;
        alu_op_e  alu_op;
        logic     pc_sel;
        logic [2:0] funct3;
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
        logic     illegal;
`endif
    } ctrl_t;

    // Per-stage controls carried past execute.
    typedef struct packed {
        logic     reg_write;
        res_src_e result_src;
        logic     mem_write;
    } stage_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Register/immediate ALU ops share one funct3 map; alt selects SUB/SRA.
    function automatic alu_op_e alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // ----------------------------------------------------------------- decode
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      dec;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign funct7 = instr_d[31:25];

    // Register-number fields are not control information.
    logic unused_fields;
    assign unused_fields = ^{instr_d[24:15], instr_d[11:7]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        dec       = CTRL_BUBBLE;
        imm_src_d = IMM_I;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = alu_arith(funct3, instr_d[30]);
                end else begin
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
                    dec.illegal = 1'b1;
`endif
                end
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                // bit 30 is part of the immediate except for right shifts
                dec.alu_op    = alu_arith(funct3, (funct3 == 3'b101) & instr_d[30]);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                imm_src_d     = IMM_S;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                imm_src_d  = IMM_B;
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
                dec.funct3 = funct3;
            end
            OP_JAL: begin
                imm_src_d      = IMM_J;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.jump       = 1'b1;
                dec.pc_sel     = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_LUI: begin
                imm_src_d     = IMM_U;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_PASSB;
            end
            default: begin
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
    end

    // -------------------------------------------------------- D->E register
    ctrl_t ctrl_q, ctrl_d;

    // A taken branch/jump in E squashes the wrong-path instruction in decode,
    // regardless of en_e; a simultaneous flush_e collapses into the same bubble.
    always_comb begin
        ctrl_d = ctrl_q;
        if (flush_e || pc_src_e) begin
            ctrl_d = CTRL_BUBBLE;
        end else if (en_e) begin
            ctrl_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            ctrl_q <= CTRL_BUBBLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // ------------------------------------------------------ branch resolve
    logic cond;

    always_comb begin
        cond = 1'b0;
        case (ctrl_q.funct3)
            3'b000:  cond = zero_e;
            3'b001:  cond = ~zero_e;
            3'b100:  cond = lt_e;
            3'b101:  cond = ~lt_e;
            3'b110:  cond = ltu_e;
            3'b111:  cond = ~ltu_e;
            default: cond = 1'b0;
        endcase
    end

    assign pc_src_e   = ctrl_q.jump | (ctrl_q.branch & cond);
    assign flush_d_o  = pc_src_e;
    assign pc_sel_e   = ctrl_q.pc_sel;
    assign alu_src_e  = ctrl_q.alu_src;
    assign alu_ctrl_e = ALU_CTRL_W'(ctrl_q.alu_op);

    // ------------------------------------------------------------ stage chain
    // stage_w[0] is the E stage itself; stages 1.. shift every cycle and are
    // deliberately not gated by en_e.
    stage_t stage_w [PIPE_DEPTH];

    assign stage_w[0] = '{reg_write:  ctrl_q.reg_write,
                          result_src: ctrl_q.result_src,
                          mem_write:  ctrl_q.mem_write};

    for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_stage
        stage_t stage_q;

        // NOTE: these are control registers, not storage arrays, so each one
        // is reset; a stale mem_write after reset would corrupt memory.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_w[k-1];
            end
        end

        assign stage_w[k] = stage_q;
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_out
        assign reg_write_s[k]         = stage_w[k].reg_write;
        assign result_src_s[2*k +: 2] = stage_w[k].result_src;
        assign mem_write_s[k]         = stage_w[k].mem_write;
    end

    // ------------------------------------------------------- illegal trap
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
    logic illegal_sticky_q, illegal_sticky_d;

    assign illegal_e        = ctrl_q.illegal;
    assign illegal_sticky_d = illegal_sticky_q | ctrl_q.illegal;
    assign illegal_sticky   = illegal_sticky_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_sticky_q <= 1'b0;
        end else begin
            illegal_sticky_q <= illegal_sticky_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_cu.sv
// -----------------------------------------------------------------------------
// tb_pipe_cu -- self-checking bench for pipe_cu (default parameters).
// A behavioural model (instruction decode table + history of E-stage words)
// predicts every output; a negedge process compares it each cycle, and the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_cu;

    localparam int AW = 4;
    localparam int PD = 3;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_JALR = 32'h000080E7;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_LUI  = 32'h000010B7;
    localparam logic [31:0] I_SRAI = 32'h4030D093;
    localparam logic [31:0] I_ADDI = 32'h40008093;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_MUL  = 32'h023100B3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     instr_d;
    logic            en_e, flush_e, zero_e, lt_e, ltu_e;
    logic [2:0]      imm_src_d;
    logic            alu_src_e;
    logic [AW-1:0]   alu_ctrl_e;
    logic            pc_src_e, pc_sel_e, flush_d_o;
    logic [PD-1:0]   reg_write_s;
    logic [2*PD-1:0] result_src_s;
    logic [PD-1:0]   mem_write_s;
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
    logic            illegal_e, illegal_sticky;
`endif

    pipe_cu #(.ALU_CTRL_W(AW), .PIPE_DEPTH(PD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_d      (instr_d),
        .en_e         (en_e),
        .flush_e      (flush_e),
        .zero_e       (zero_e),
        .lt_e         (lt_e),
        .ltu_e        (ltu_e),
        .imm_src_d    (imm_src_d),
        .alu_src_e    (alu_src_e),
        .alu_ctrl_e   (alu_ctrl_e),
        .pc_src_e     (pc_src_e),
        .pc_sel_e     (pc_sel_e),
        .flush_d_o    (flush_d_o),
        .reg_write_s  (reg_write_s),
        .result_src_s (result_src_s),
        .mem_write_s  (mem_write_s)
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
        ,
        .illegal_e      (illegal_e),
        .illegal_sticky (illegal_sticky)
`endif
    );

    always #50 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct packed {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       br;
        bit       jmp;
        bit       asrc;
        bit [3:0] op;
        bit       psel;
        bit [2:0] f3;
        bit       ill;
        bit [2:0] imm;
    } m_t;

    // Decode table: what each RV32I instruction class must produce.
    function automatic m_t model_dec(input logic [31:0] ins);
        m_t m = '0;
        bit [2:0] f3 = ins[14:12];
        bit [3:0] arith [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        case (ins[6:0])
            7'h33: if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) begin
                       m.rw = 1; m.op = arith[f3];
                       if (ins[30] && f3 == 3'd0) m.op = 4'd1;
                       if (ins[30] && f3 == 3'd5) m.op = 4'd9;
                   end else m.ill = 1;
            7'h13: begin
                       m.rw = 1; m.asrc = 1; m.op = arith[f3];
                       if (ins[30] && f3 == 3'd5) m.op = 4'd9;
                   end
            7'h03: begin m.rw = 1; m.asrc = 1; m.rs = 2'b01; end
            7'h23: begin m.imm = 3'd1; m.asrc = 1; m.mw = 1; end
            7'h63: begin m.imm = 3'd2; m.op = 4'd1; m.br = 1; m.f3 = f3; end
            7'h6F: begin m.imm = 3'd3; m.rw = 1; m.jmp = 1; m.rs = 2'b10; end
            7'h67: begin m.rw = 1; m.asrc = 1; m.jmp = 1; m.psel = 1; m.rs = 2'b10; end
            7'h37: begin m.imm = 3'd4; m.rw = 1; m.asrc = 1; m.op = 4'd10; end
            default: m.ill = 1;
        endcase
        return m;
    endfunction

    function automatic bit model_taken(input m_t e, input bit z, input bit lt, input bit ltu);
        bit c;
        case (e.f3)
            3'd0: c = z;
            3'd1: c = !z;
            3'd4: c = lt;
            3'd5: c = !lt;
            3'd6: c = ltu;
            3'd7: c = !ltu;
            default: c = 0;
        endcase
        return e.jmp || (e.br && c);
    endfunction

    // m_st[0] is the word in E, m_st[k] the controls k stages later.
    m_t m_st [4];
    bit m_sticky = 0;
    bit m_valid  = 0;

    always @(posedge clk) begin
        bit taken;
        m_t nxt;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_st[k] = '0;
            m_sticky = 0;
            m_valid  = 1;
        end else if (m_valid) begin
            taken    = model_taken(m_st[0], zero_e, lt_e, ltu_e);
            m_sticky = m_sticky | m_st[0].ill;
            nxt      = m_st[0];
            if (flush_e || taken) nxt = '0;
            else if (en_e)        nxt = model_dec(instr_d);
            // only the control bits ride down the chain
            nxt.imm  = '0;
            for (int k = 3; k > 0; k--) m_st[k] = m_st[k-1];
            m_st[0] = nxt;
        end
    end

    always @(negedge clk) begin
        m_t d;
        logic [PD-1:0]   e_rw, e_mw;
        logic [2*PD-1:0] e_rs;
        bit taken;
        if (m_valid) begin
            d     = model_dec(instr_d);
            taken = model_taken(m_st[0], zero_e, lt_e, ltu_e);
            for (int k = 0; k < PD; k++) begin
                e_rw[k]        = m_st[k].rw;
                e_mw[k]        = m_st[k].mw;
                e_rs[2*k +: 2] = m_st[k].rs;
            end
            check("cyc imm_src_d",    32'(imm_src_d),    32'(d.imm));
            check("cyc pc_src_e",     32'(pc_src_e),     32'(taken));
            check("cyc flush_d_o",    32'(flush_d_o),    32'(taken));
            check("cyc pc_sel_e",     32'(pc_sel_e),     32'(m_st[0].psel));
            check("cyc alu_src_e",    32'(alu_src_e),    32'(m_st[0].asrc));
            check("cyc alu_ctrl_e",   32'(alu_ctrl_e),   32'(m_st[0].op));
            check("cyc reg_write_s",  32'(reg_write_s),  32'(e_rw));
            check("cyc result_src_s", 32'(result_src_s), 32'(e_rs));
            check("cyc mem_write_s",  32'(mem_write_s),  32'(e_mw));
`ifdef PIPE_CU_ILLEGAL_TRAP_EN
            check("cyc illegal_e",      32'(illegal_e),      32'(m_st[0].ill));
            check("cyc illegal_sticky", 32'(illegal_sticky), 32'(m_sticky | m_st[0].ill));
`endif
        end
    end

    // -------------------------------------------------------------- stimulus
    // Drive one cycle's inputs just after the falling edge, then return 1 ns
    // after the rising edge that consumes them.
    task automatic drv(input logic [31:0] ins, input bit en, input bit fl,
                       input bit z, input bit lt, input bit ltu);
        @(negedge clk);
        #1;
        instr_d = ins; en_e = en; flush_e = fl;
        zero_e = z; lt_e = lt; ltu_e = ltu;
        @(posedge clk);
        #1;
    endtask

    int       f3s [7] = '{0, 1, 4, 5, 6, 7, 2};
    bit [7:0] tbl [7] = '{8'hF0, 8'h0F, 8'hCC, 8'h33, 8'hAA, 8'h55, 8'h00};

    initial begin
        bit [7:0] row;
        rst_n = 0; instr_d = I_ADD; en_e = 1; flush_e = 0;
        zero_e = 0; lt_e = 0; ltu_e = 0;

        // reset holds everything at bubble
        for (int i = 0; i < 2; i++) begin
            drv(I_ADD, 1, 0, 0, 0, 0);
            check("rst reg_write_s",  32'(reg_write_s),  0);
            check("rst result_src_s", 32'(result_src_s), 0);
            check("rst mem_write_s",  32'(mem_write_s),  0);
            check("rst pc_src_e",     32'(pc_src_e),     0);
            check("rst alu_ctrl_e",   32'(alu_ctrl_e),   0);
        end
        rst_n = 1;
        drv(I_ADD, 1, 0, 0, 0, 0);
        check("post-rst reg_write_s[0]", 32'(reg_write_s[0]), 1);
        check("post-rst alu_ctrl_e",     32'(alu_ctrl_e),     0);

        // load travels down the chain, one stage per cycle
        drv(I_LW, 1, 0, 0, 0, 0);
        check("lw stage0 result_src", 32'(result_src_s[1:0]), 32'h1);
        check("lw mem_write_s c1",    32'(mem_write_s),       0);
        drv(I_NOP, 1, 0, 0, 0, 0);
        check("lw stage1 result_src", 32'(result_src_s[3:2]), 32'h1);
        check("nop stage0 result_src", 32'(result_src_s[1:0]), 0);
        drv(I_NOP, 1, 0, 0, 0, 0);
        check("lw stage2 result_src", 32'(result_src_s[5:4]), 32'h1);
        check("lw mem_write_s c3",    32'(mem_write_s),       0);

        // branch matrix: every flag combination for each funct3
        for (int i = 0; i < 7; i++) begin
            drv(I_NOP, 1, 0, 0, 0, 0);
            drv(I_BEQ | (32'(f3s[i]) << 12), 1, 0, 0, 0, 0);
            row = tbl[i];
            for (int c = 0; c < 8; c++) begin
                zero_e = c[2]; lt_e = c[1]; ltu_e = c[0];
                #2;
                check($sformatf("br f3=%0d flags=%0d pc_src_e", f3s[i], c), 32'(pc_src_e), 32'(row[c]));
                check($sformatf("br f3=%0d flags=%0d flush_d_o", f3s[i], c), 32'(flush_d_o), 32'(row[c]));
            end
        end

        // taken beq squashes the sw behind it
        drv(I_NOP, 1, 0, 0, 0, 0);
        drv(I_BEQ, 1, 0, 1, 0, 0);
        check("selfflush pc_src_e",  32'(pc_src_e),  1);
        check("selfflush flush_d_o", 32'(flush_d_o), 1);
        drv(I_SW, 1, 0, 1, 0, 0);
        check("sw imm_src_d",       32'(imm_src_d),      32'h1);
        check("squashed sw mw[0]",  32'(mem_write_s[0]), 0);
        check("squashed sw pc_src", 32'(pc_src_e),       0);
        for (int i = 0; i < 3; i++) begin
            drv(I_NOP, 1, 0, 0, 0, 0);
            check("squashed sw never writes", 32'(mem_write_s), 0);
        end

        // stall holds E; stall + flush gives a bubble
        drv(I_LW, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(I_ADD, 0, 0, 0, 0, 0);
            check("stall held result_src", 32'(result_src_s[1:0]), 32'h1);
            check("stall held alu_src",    32'(alu_src_e),         1);
            check("stall held reg_write",  32'(reg_write_s[0]),    1);
        end
        drv(I_ADD, 0, 1, 0, 0, 0);
        check("stall+flush reg_write", 32'(reg_write_s[0]),    0);
        check("stall+flush result",    32'(result_src_s[1:0]), 0);

        // jalr
        drv(I_JALR, 1, 0, 0, 0, 0);
        check("jalr pc_src_e",   32'(pc_src_e),          1);
        check("jalr pc_sel_e",   32'(pc_sel_e),          1);
        check("jalr result_src", 32'(result_src_s[1:0]), 32'h2);
        drv(I_NOP, 1, 0, 0, 0, 0);
        check("after jalr pc_src_e",   32'(pc_src_e),          0);
        check("after jalr stage1 res", 32'(result_src_s[3:2]), 32'h2);
        check("after jalr rw[0]",      32'(reg_write_s[0]),    0);

        // jal with a coincident flush_e: a single bubble
        drv(I_JAL, 1, 0, 0, 0, 0);
        check("jal pc_src_e", 32'(pc_src_e), 1);
        check("jal pc_sel_e", 32'(pc_sel_e), 0);
        drv(I_ADD, 1, 1, 0, 0, 0);
        check("jal+flush bubble", 32'(reg_write_s[0]), 0);
        drv(I_ADD, 1, 0, 0, 0, 0);
        check("after bubble rw[0]", 32'(reg_write_s[0]), 1);

        // assorted decodes
        drv(I_SUB, 1, 0, 0, 0, 0);
        check("sub alu_ctrl", 32'(alu_ctrl_e), 32'd1);
        drv(I_LUI, 1, 0, 0, 0, 0);
        check("lui alu_ctrl",  32'(alu_ctrl_e), 32'd10);
        check("lui imm_src_d", 32'(imm_src_d),  32'd4);
        drv(I_SRAI, 1, 0, 0, 0, 0);
        check("srai alu_ctrl", 32'(alu_ctrl_e), 32'd9);
        drv(I_ADDI, 1, 0, 0, 0, 0);
        check("addi bit30 alu_ctrl", 32'(alu_ctrl_e), 32'd0);
        drv(I_BAD, 1, 0, 0, 0, 0);
        check("bad opcode rw[0]", 32'(reg_write_s[0]), 0);
        check("bad opcode mw[0]", 32'(mem_write_s[0]), 0);
        drv(I_MUL, 1, 0, 0, 0, 0);
        check("bad funct7 rw[0]", 32'(reg_write_s[0]), 0);

        // reset in the middle of traffic
        drv(I_LW, 1, 0, 0, 0, 0);
        drv(I_JAL, 1, 0, 0, 0, 0);
        rst_n = 0;
        drv(I_NOP, 1, 0, 0, 0, 0);
        check("midrst reg_write_s",  32'(reg_write_s),  0);
        check("midrst result_src_s", 32'(result_src_s), 0);
        check("midrst pc_src_e",     32'(pc_src_e),     0);
        rst_n = 1;

`ifdef PIPE_CU_ILLEGAL_TRAP_EN
        drv(I_BAD, 1, 0, 0, 0, 0);
        check("illegal_e set",      32'(illegal_e),      1);
        check("illegal_sticky set", 32'(illegal_sticky), 1);
        for (int i = 0; i < 2; i++) begin
            drv(I_NOP, 1, 0, 0, 0, 0);
            check("illegal_e clears",    32'(illegal_e),      0);
            check("illegal_sticky holds", 32'(illegal_sticky), 1);
        end
        drv(I_BAD, 1, 1, 0, 0, 0);
        check("flushed illegal_e", 32'(illegal_e), 0);
        rst_n = 0;
        drv(I_NOP, 1, 0, 0, 0, 0);
        check("rst illegal_sticky", 32'(illegal_sticky), 0);
        rst_n = 1;
`endif
        drv(I_NOP, 1, 0, 0, 0, 0);
        drv(I_NOP, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
